// File: rtl/clt_gaussian_noise.sv
// Central-limit Gaussian noise: sums 2^SUM_LOG2 uniform LFSR words, removes the mean and scales
// to a signed sample, emitting Z_DIM samples per start. Optional: CLT_NOISE_SCALE_EN adds scale_shift.
module clt_gaussian_noise #(
    parameter int DATA_WIDTH = 16,
    parameter int SUM_LOG2   = 2,
    parameter int OUT_WIDTH  = 16,
    parameter int Z_DIM      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] noise_in,
    input  logic                  noise_valid,
    output logic                  noise_req,
    output logic [OUT_WIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done
`ifdef CLT_NOISE_SCALE_EN
    ,
    input  logic [3:0]            scale_shift
`endif
);

    localparam int ACC_W = DATA_WIDTH + SUM_LOG2;
    localparam int N     = 1 << SUM_LOG2;
    localparam int SHIFT = ACC_W - OUT_WIDTH;
    localparam int EW    = (Z_DIM > 1) ? $clog2(Z_DIM) : 1;
    // Mean of the sum of N uniform words, subtracted to centre the result on zero.
    localparam logic [ACC_W:0] BIAS = (ACC_W + 1)'(N) << (DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    state_t                 state_reg, state_next;
    logic [ACC_W-1:0]       acc_reg, acc_next;
    logic [SUM_LOG2-1:0]    samp_reg, samp_next;
    logic [EW-1:0]          elem_reg, elem_next;
    logic [OUT_WIDTH-1:0]   m_tdata_reg, m_tdata_next;
    logic                   m_tvalid_reg, m_tvalid_next;
    logic                   m_tlast_reg, m_tlast_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;

    logic                   accept;
    logic                   last_word;
    logic                   handshake;
    logic                   last_elem;
    logic [ACC_W-1:0]       final_sum;
    logic signed [ACC_W:0]  centered;
    logic signed [ACC_W:0]  shifted_full;
    logic signed [OUT_WIDTH-1:0] unscaled;
    logic signed [OUT_WIDTH-1:0] scaled;

    assign accept    = (state_reg == S_ACCUM) && noise_valid;
    assign last_word = accept && (samp_reg == SUM_LOG2'(N - 1));
    assign handshake = (state_reg == S_OUTPUT) && m_tvalid_reg && m_tready;
    assign last_elem = (elem_reg == EW'(Z_DIM - 1));

    // The final sum includes the word arriving this cycle so the sample registers without delay.
    assign final_sum    = acc_reg + ACC_W'(noise_in);
    assign centered     = {1'b0, final_sum} - BIAS;
    assign shifted_full = centered >>> SHIFT;
    assign unscaled     = shifted_full[OUT_WIDTH-1:0];

`ifdef CLT_NOISE_SCALE_EN
    always_comb begin
        scaled = unscaled >>> scale_shift;
        if (32'(scale_shift) >= OUT_WIDTH) begin
            scaled = {OUT_WIDTH{unscaled[OUT_WIDTH-1]}};
        end
    end
`else
    assign scaled = unscaled;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_ACCUM;
            S_ACCUM:  if (last_word) state_next = S_OUTPUT;
            S_OUTPUT: if (handshake) state_next = m_tlast_reg ? S_IDLE : S_ACCUM;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        noise_req     = (state_reg == S_ACCUM);
        acc_next      = acc_reg;
        samp_next     = samp_reg;
        elem_next     = elem_reg;
        m_tdata_next  = m_tdata_reg;
        m_tvalid_next = m_tvalid_reg;
        m_tlast_next  = m_tlast_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    acc_next  = '0;
                    samp_next = '0;
                    elem_next = '0;
                    busy_next = 1'b1;
                end
            end
            S_ACCUM: begin
                if (last_word) begin
                    m_tdata_next  = scaled;
                    m_tvalid_next = 1'b1;
                    m_tlast_next  = last_elem;
                    acc_next      = '0;
                    samp_next     = '0;
                end else if (accept) begin
                    acc_next  = final_sum;
                    samp_next = samp_reg + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (handshake) begin
                    m_tvalid_next = 1'b0;
                    if (m_tlast_reg) begin
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        elem_next = elem_reg + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            samp_reg     <= '0;
            elem_reg     <= '0;
            m_tdata_reg  <= '0;
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            samp_reg     <= samp_next;
            elem_reg     <= elem_next;
            m_tdata_reg  <= m_tdata_next;
            m_tvalid_reg <= m_tvalid_next;
            m_tlast_reg  <= m_tlast_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign m_tdata  = m_tdata_reg;
    assign m_tvalid = m_tvalid_reg;
    assign m_tlast  = m_tlast_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_clt_gaussian_noise.sv
// Bench for clt_gaussian_noise: directed and randomized vectors against a behavioural model.
module tb_clt_gaussian_noise;

    localparam int DW = 16;
    localparam int SL = 2;
    localparam int OW = 16;
    localparam int ZD = 4;
    localparam int N  = 1 << SL;
    localparam int SH = DW + SL - OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] noise_in = '0;
    logic          noise_valid = 1'b0;
    logic          noise_req;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic [3:0]    scale_shift = 4'd0;

    int total = 0;
    int bad   = 0;

    // Model state: phase 0=idle, 1=collecting words, 2=presenting a sample.
    int ph = 0, cnt = 0, sum = 0, elem = 0, e_data = 0;
    bit e_valid = 0, e_last = 0, e_busy = 0, e_done = 0;

    clt_gaussian_noise #(
        .DATA_WIDTH(DW), .SUM_LOG2(SL), .OUT_WIDTH(OW), .Z_DIM(ZD)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .noise_in(noise_in), .noise_valid(noise_valid), .noise_req(noise_req),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done)
`ifdef CLT_NOISE_SCALE_EN
        , .scale_shift(scale_shift)
`endif
    );

    always #5 clk = ~clk;

    function automatic int fdiv(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Mean-removed sum scaled down with floor rounding, then optional extra scaling.
    function automatic int gauss(int s, int sc);
        int q;
        q = fdiv(s - N * (1 << (DW - 1)), 1 << SH);
        if (sc >= OW) q = (q < 0) ? -1 : 0;
        else          q = fdiv(q, 1 << sc);
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] ed;
        ed = e_data[15:0];
        check("noise_req", {31'd0, noise_req}, {31'd0, ph == 1});
        check("m_tvalid", {31'd0, m_tvalid}, {31'd0, e_valid});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("done", {31'd0, done}, {31'd0, e_done});
        if (e_valid) begin
            check("m_tdata", {16'd0, m_tdata}, {16'd0, ed});
            check("m_tlast", {31'd0, m_tlast}, {31'd0, e_last});
        end
    endtask

    task automatic cycle(input bit st, input bit nv, input logic [15:0] nw, input bit rdy,
                         input logic [3:0] sc);
        int sc_eff;
        start = st; noise_valid = nv; noise_in = nw; m_tready = rdy; scale_shift = sc;
`ifdef CLT_NOISE_SCALE_EN
        sc_eff = int'(sc);
`else
        sc_eff = 0;
`endif
        e_done = 0;
        case (ph)
            0: if (st) begin ph = 1; cnt = 0; sum = 0; elem = 0; e_busy = 1; end
            1: if (nv) begin
                sum += int'(nw);
                cnt++;
                if (cnt == N) begin
                    e_data = gauss(sum, sc_eff); e_valid = 1; e_last = (elem == ZD - 1);
                    ph = 2; cnt = 0; sum = 0;
                end
            end
            default: if (rdy) begin
                e_valid = 0;
                if (e_last) begin ph = 0; e_done = 1; e_busy = 0; end
                else begin elem++; ph = 1; end
            end
        endcase
        @(posedge clk); #1;
        $display("cyc t=%0t st=%0b nv=%0b nw=%h rdy=%0b -> req=%0b v=%0b d=%h l=%0b busy=%0b done=%0b",
                 $time, st, nv, nw, rdy, noise_req, m_tvalid, m_tdata, m_tlast, busy, done);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1; start = 0; noise_valid = 1; m_tready = 1;
        @(posedge clk); #1;
        rst = 0;
        ph = 0; cnt = 0; sum = 0; elem = 0; e_data = 0;
        e_valid = 0; e_last = 0; e_busy = 0; e_done = 0;
        check("rst_tdata", {16'd0, m_tdata}, 32'd0);
        check("rst_tlast", {31'd0, m_tlast}, 32'd0);
        check_outputs();
    endtask

    // Drive until the model sees the vector end; running out of budget is a failure.
    task automatic finish_vec(input bit rnd, input logic [15:0] cw, input int vpct, input int rpct,
                              input bit rnd_sc, input logic [3:0] sc);
        int n = 0;
        do begin
            cycle(1'b0, $urandom_range(99) < vpct, rnd ? 16'($urandom) : cw,
                  $urandom_range(99) < rpct, rnd_sc ? 4'($urandom) : sc);
            n++;
        end while (!e_done && n < 2000);
        check("vec_end_done", {31'd0, done}, 32'd1);
        check("vec_end_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        do_reset();

        // Constant mid-scale words give zero samples.
        cycle(1, 0, 16'h0, 1, 0);
        finish_vec(0, 16'h8000, 100, 100, 0, 0);
        // Full-scale extremes.
        cycle(1, 0, 16'h0, 1, 0);
        finish_vec(0, 16'hFFFF, 100, 100, 0, 0);
        cycle(1, 0, 16'h0, 1, 0);
        finish_vec(0, 16'h0000, 100, 100, 0, 0);

        // Mixed words with gaps, then a trailing word that must be discarded.
        cycle(1, 0, 16'h0, 1, 0);
        cycle(0, 0, 16'h1234, 1, 0);
        cycle(0, 1, 16'h0000, 1, 0);
        cycle(0, 0, 16'h4321, 1, 0);
        cycle(0, 1, 16'hFFFF, 1, 0);
        cycle(0, 0, 16'h0, 1, 0);
        cycle(0, 0, 16'h0, 1, 0);
        cycle(0, 1, 16'h8000, 1, 0);
        cycle(0, 1, 16'h8000, 0, 0);
        check("gap_sum_minus1", {16'd0, m_tdata}, 32'h0000FFFF);
        cycle(0, 1, 16'hFFFF, 1, 0);
        finish_vec(1, 16'h0, 80, 80, 0, 0);

        // Back-pressure with a stray start while busy.
        cycle(1, 0, 16'h0, 1, 0);
        for (int i = 0; i < N; i++) cycle(0, 1, 16'($urandom), 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 16'($urandom), 0, 0);
        finish_vec(1, 16'h0, 90, 90, 0, 0);

        // Abort mid-accumulation, then a clean vector.
        cycle(1, 0, 16'h0, 1, 0);
        cycle(0, 1, 16'hFFFF, 1, 0);
        cycle(0, 1, 16'hFFFF, 1, 0);
        do_reset();
        cycle(1, 0, 16'h0, 1, 0);
        finish_vec(1, 16'h0, 100, 100, 0, 0);

        // Start on the same cycle the done pulse is visible.
        cycle(1, 1, 16'h0, 1, 0);
        finish_vec(1, 16'h0, 75, 75, 0, 0);

`ifdef CLT_NOISE_SCALE_EN
        cycle(1, 0, 16'h0, 1, 3);
        finish_vec(0, 16'hFFFF, 100, 100, 0, 3);
        cycle(1, 0, 16'h0, 1, 15);
        finish_vec(0, 16'h0000, 100, 100, 0, 15);
        for (int v = 0; v < 4; v++) begin
            cycle(1, 0, 16'h0, 1, 0);
            finish_vec(1, 16'h0, 70, 60, 1, 0);
        end
`endif

        for (int v = 0; v < 6; v++) begin
            cycle(1, $urandom_range(1), 16'($urandom), 1, 0);
            finish_vec(1, 16'h0, 70, 60, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
